// File: rtl/fmap_pkg.sv
// Shared definitions for the 256-bit feature-map capture/replay paths: word
// geometry, column layout helper and the common sequencing state encoding.
package fmap_pkg;

    localparam int PIXELS_PER_WORD = 16;
    localparam int BRAM_WORD_W     = 256;
    localparam int PIX_BITS        = BRAM_WORD_W / PIXELS_PER_WORD;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } fmap_state_e;

    function automatic int words_per_col(input int pix_h);
        return (pix_h + PIXELS_PER_WORD - 1) / PIXELS_PER_WORD;
    endfunction

endpackage

// File: rtl/fmap_word_unpack.sv
// Slices one packed BRAM word into its 16 pixel lanes (lane 0 = bits [15:0]).
// Build option FMAP_REPLAY_RELU_EN: negative (signed) pixels are clamped to 0.
module fmap_word_unpack
    import fmap_pkg::*;
(
    input  logic [BRAM_WORD_W-1:0] word_i,
    output logic [PIX_BITS-1:0]    pix_o [PIXELS_PER_WORD]
);

    always_comb begin
        for (int l = 0; l < PIXELS_PER_WORD; l++) begin
`ifdef FMAP_REPLAY_RELU_EN
            pix_o[l] = word_i[l*PIX_BITS + PIX_BITS - 1] ? '0 : word_i[l*PIX_BITS +: PIX_BITS];
`else
            pix_o[l] = word_i[l*PIX_BITS +: PIX_BITS];
`endif
        end
    end

endmodule

// File: rtl/fmap_replay_256.sv
// Replays a stored feature map from the result BRAM one column at a time,
// rebuilding each column from packed words. Build option: FMAP_REPLAY_RELU_EN.
//
// state   | meaning
// IDLE    | waiting for start
// READ    | issuing the column's word reads and capturing returned words
// PRESENT | column held on data_col with valid_col until accepted
// DONE    | whole map replayed; done held until the next start
module fmap_replay_256
    import fmap_pkg::*;
#(
    parameter int          DATA_WIDTH = 16,
    parameter int          PIX_H      = 24,
    parameter int          PIX_W      = 24,
    parameter logic [11:0] BASE_ADDR  = 12'h000,
    parameter int          RD_LATENCY = 1
) (
    input  logic                   out_stream_aclk,
    input  logic                   periph_resetn,
    input  logic                   start,
    output logic [11:0]            bram_addr_b,
    output logic                   bram_en_b,
    input  logic [BRAM_WORD_W-1:0] bram_rddata_b,
    output logic [DATA_WIDTH-1:0]  data_col [PIX_H-1:0],
    output logic                   valid_col,
    input  logic                   ready_col,
    output logic                   busy,
    output logic                   done
);

    localparam int WPC       = words_per_col(PIX_H);
    localparam int WIW       = (WPC > 1) ? $clog2(WPC) : 1;
    localparam int IW        = $clog2(WPC + 1);
    localparam int COLW      = (PIX_W > 1) ? $clog2(PIX_W) : 1;
    localparam int LAST_ADDR = int'(BASE_ADDR) + PIX_W * WPC - 1;

    if (LAST_ADDR > 4095) begin : g_addr_chk
        $error("fmap_replay_256: feature map does not fit the 12-bit BRAM address space");
    end
    if (DATA_WIDTH != PIX_BITS) begin : g_width_chk
        $error("fmap_replay_256: DATA_WIDTH must be 16");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_lat_chk
        $error("fmap_replay_256: RD_LATENCY must be 1 or 2");
    end

    fmap_state_e           state_q;
    logic [COLW-1:0]       col_q;
    logic [11:0]           col_base_q;
    logic [IW-1:0]         issue_q;
    logic [11:0]           addr_q;
    logic                  en_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] data_col_q [PIX_H-1:0];
    logic [11:0]           rd_addr_d;

    // Stage 0 tracks the address currently on the bus; stage RD_LATENCY
    // lines up with the word arriving on bram_rddata_b.
    logic                  tag_vld_q [RD_LATENCY+1];
    logic [WIW-1:0]        tag_idx_q [RD_LATENCY+1];

    logic [PIX_BITS-1:0]   unp_pix [PIXELS_PER_WORD];

    fmap_word_unpack u_unpack (
        .word_i (bram_rddata_b),
        .pix_o  (unp_pix)
    );

    assign rd_addr_d = col_base_q + 12'(issue_q);

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_q    <= IDLE;
            col_q      <= '0;
            col_base_q <= '0;
            issue_q    <= '0;
            addr_q     <= '0;
            en_q       <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int p = 0; p < PIX_H; p++) data_col_q[p] <= '0;
            for (int i = 0; i <= RD_LATENCY; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_idx_q[i] <= '0;
            end
        end else begin
            en_q         <= 1'b0;
            tag_vld_q[0] <= 1'b0;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end

            if (tag_vld_q[RD_LATENCY]) begin
                for (int p = 0; p < PIX_H; p++) begin
                    if (tag_idx_q[RD_LATENCY] == WIW'(p / PIXELS_PER_WORD))
                        data_col_q[p] <= unp_pix[p % PIXELS_PER_WORD];
                end
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= READ;
                        col_q      <= '0;
                        col_base_q <= BASE_ADDR;
                        issue_q    <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                READ: begin
                    if (issue_q < IW'(WPC)) begin
                        addr_q       <= rd_addr_d;
                        en_q         <= 1'b1;
                        tag_vld_q[0] <= 1'b1;
                        tag_idx_q[0] <= WIW'(issue_q);
                        issue_q      <= issue_q + 1'b1;
                    end
                    if (tag_vld_q[RD_LATENCY] && tag_idx_q[RD_LATENCY] == WIW'(WPC - 1)) begin
                        state_q <= PRESENT;
                        valid_q <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (ready_col) begin
                        valid_q <= 1'b0;
                        if (col_q == COLW'(PIX_W - 1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= READ;
                            col_q      <= col_q + 1'b1;
                            col_base_q <= col_base_q + 12'(WPC);
                            issue_q    <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bram_addr_b = addr_q;
    assign bram_en_b   = en_q;
    assign data_col    = data_col_q;
    assign valid_col   = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
